// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch controller and its fetch buffer.
package if_pkg;

  localparam int unsigned PKG_XLEN    = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
    logic                filled;
    logic                misalign;
  } buf_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Circular fetch buffer: entries are allocated at request time and filled in order
// as responses return; the head is presented once filled.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                alloc_i,
  input  logic [PKG_XLEN-1:0] alloc_pc_i,
  input  logic                alloc_filled_i,
  input  logic                alloc_misalign_i,
  input  logic                fill_i,
  input  logic [INSTR_W-1:0]  fill_instr_i,
  input  logic                pop_i,
  output buf_entry_t          head_o,
  output logic                head_valid_o,
  output logic [CW-1:0]       occ_o
);

  buf_entry_t        mem_q [DEPTH];
  logic [AW-1:0]     alloc_ptr_q, fill_ptr_q, pop_ptr_q;
  logic [CW-1:0]     occ_q;

  // Flush dominates; alloc, fill and pop always touch distinct slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      occ_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      occ_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        mem_q[alloc_ptr_q] <= '{pc: alloc_pc_i, instr: '0,
                                filled: alloc_filled_i, misalign: alloc_misalign_i};
        alloc_ptr_q <= alloc_ptr_q + AW'(1);
      end
      if (fill_i) begin
        mem_q[fill_ptr_q].instr  <= fill_instr_i;
        mem_q[fill_ptr_q].filled <= 1'b1;
      end
      // A pre-filled allocation is only made with nothing pending, so fill tracks alloc.
      if (fill_i || (alloc_i && alloc_filled_i)) fill_ptr_q <= fill_ptr_q + AW'(1);
      if (pop_i) begin
        mem_q[pop_ptr_q].filled <= 1'b0;
        pop_ptr_q <= pop_ptr_q + AW'(1);
      end
      occ_q <= occ_q + CW'(alloc_i) - CW'(pop_i);
    end
  end

  assign head_o       = mem_q[pop_ptr_q];
  assign head_valid_o = (occ_q != '0) && mem_q[pop_ptr_q].filled;
  assign occ_o        = occ_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues word fetches, buffers in-order responses for ID,
// and drops in-flight fetches after a redirect. Optional misaligned-PC trap: IF_MISALIGN_TRAP_EN.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned     XLEN       = PKG_XLEN,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            id_misalign_o
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_state_e  state_q, state_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] occ;
  logic          credit, issue_ok, req_valid, fire, fill, pop, trap_alloc;
  buf_entry_t    head;
  logic          head_valid;

  assign credit   = occ < CW'(FIFO_DEPTH);
  assign issue_ok = rst && (state_q == RUN) && !redirect_i && credit;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign, trap_q;

  // A misaligned PC becomes one pre-filled NOP entry, then fetch parks until redirect.
  assign misalign   = pc_i[1:0] != 2'b00;
  assign req_valid  = issue_ok && !misalign;
  assign trap_alloc = issue_ok && misalign && !trap_q && (outst_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trap_q <= 1'b0;
    else      trap_q <= redirect_i ? 1'b0 : (trap_q | trap_alloc);
  end

  assign id_misalign_o = head_valid && head.misalign;
`else
  assign req_valid  = issue_ok;
  assign trap_alloc = 1'b0;
`endif

  assign fire = req_valid && imem_req_ready_i;
  assign fill = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
  assign pop  = head_valid && id_ready_i && !redirect_i;

  if_fetch_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk              (clk),
    .rst_n            (rst),
    .flush_i          (redirect_i),
    .alloc_i          (fire || trap_alloc),
    .alloc_pc_i       (PKG_XLEN'(pc_i)),
    .alloc_filled_i   (trap_alloc),
    .alloc_misalign_i (trap_alloc),
    .fill_i           (fill),
    .fill_instr_i     (imem_rsp_data_i),
    .pop_i            (pop),
    .head_o           (head),
    .head_valid_o     (head_valid),
    .occ_o            (occ)
  );

  // Drop bookkeeping: a response arriving with the redirect is discarded by the flush itself.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(fire) - CW'(imem_rsp_valid_i);
    if (redirect_i && (state_q == RUN)) begin
      drop_d = outst_q - CW'(imem_rsp_valid_i);
    end else if (imem_rsp_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    case (state_q)
      RUN:     if (redirect_i && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    pc_next_o = pc_i;
    if (!rst)            pc_next_o = RESET_PC;
    else if (redirect_i) pc_next_o = redirect_pc_i;
    else if (fire)       pc_next_o = pc_i + XLEN'(INSTR_BYTES);
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = {pc_i[XLEN-1:2], 2'b00};
  assign id_valid_o       = head_valid;
  assign id_pc_o          = XLEN'(head.pc);
  assign id_instr_o       = head.misalign ? NOP_INSTR : head.instr;

  rsp_has_req_a: assert property (@(posedge clk) disable iff (!rst)
                                  imem_rsp_valid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl with a PC register and a fixed-latency imem model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, pc_next_o;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o, id_ready_i;
  logic [31:0] id_instr_o, id_pc_o;
`ifdef IF_MISALIGN_TRAP_EN
  logic        id_misalign_o;
`endif

  if_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .pc_next_o        (pc_next_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .id_misalign_o    (id_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents: the word at address a is C0DE_<a[15:0]>.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  req_t        rq[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          fire_cnt = 0;
  logic        fire_s = 1'b0, rsp_s = 1'b0;
  logic [31:0] addr_s = '0, pcn_s = '0;

  // Mid-cycle sampling of the request channel, and the ID-side scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    fire_s = imem_req_valid_o && imem_req_ready_i;
    addr_s = imem_req_addr_o;
    rsp_s  = imem_rsp_valid_i;
    pcn_s  = pc_next_o;
    if (rst && id_valid_o && id_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_id: got pc %h, expected no delivery", id_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc_o, e.pc);
        chk("id_instr", id_instr_o, e.instr);
      end
    end
  end

  // PC register and in-order imem responder.
  always @(posedge clk) begin
    if (!rst) begin
      pc_i             <= 32'h0;
      imem_rsp_valid_i <= 1'b0;
      imem_rsp_data_i  <= 32'h0;
      rq.delete();
    end else begin
      cyc = cyc + 1;
      pc_i <= pcn_s;
      if (rsp_s) void'(rq.pop_front());
      if (fire_s) begin
        rq.push_back('{addr_s, cyc + lat - 1});
        fire_cnt = fire_cnt + 1;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        imem_rsp_valid_i <= 1'b1;
        imem_rsp_data_i  <= word_of(rq[0].addr);
      end else begin
        imem_rsp_valid_i <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b0;
    imem_req_ready_i = 1'b0;
    id_ready_i = 1'b0;
    redirect_i = 1'b0;
    lat = l;
    tick();
    tick();
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back('{pc, instr});
  endtask

  task automatic wait_pc(input logic [31:0] target, input string name);
    int n = 0;
    while (pc_i !== target && n < 40) begin
      tick();
      n++;
    end
    chk(name, pc_i, target);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    int f0;
    rst = 1'b0;
    imem_req_ready_i = 1'b0;
    id_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    tick();
    tick();
    chk("rst_id_valid", 32'(id_valid_o), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rst_pc_next", pc_next_o, 32'h0);

    // Streaming fetch, always-ready memory and ID.
    do_reset(1);
    f0 = fire_cnt;
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    push_exp(32'h8, 32'hC0DE_0008);
    #1;
    chk("t1_pc_next_c0", pc_next_o, 32'h4);
    tick();
    chk("t1_valid_c1", 32'(id_valid_o), 32'd0);
    chk("t1_pc_c1", pc_i, 32'h4);
    tick();
    chk("t1_valid_c2", 32'(id_valid_o), 32'd1);
    wait_pc(32'hC, "t1_reach_pc");
    imem_req_ready_i = 1'b0;
    wait_drain("t1_drain");
    chk("t1_fires", 32'(fire_cnt - f0), 32'd3);

    // ID stall: buffer fills, PC holds, head stays stable.
    do_reset(1);
    f0 = fire_cnt;
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b0;
    tick(); tick();
    chk("t2_valid_c2", 32'(id_valid_o), 32'd1);
    chk("t2_pc_c2", id_pc_o, 32'h0);
    chk("t2_instr_c2", id_instr_o, 32'hC0DE_0000);
    tick(); tick(); tick(); tick();
    chk("t2_fires", 32'(fire_cnt - f0), 32'd2);
    chk("t2_pc_next_held", pc_next_o, 32'h8);
    chk("t2_req_blocked", 32'(imem_req_valid_o), 32'd0);
    chk("t2_pc_c6", id_pc_o, 32'h0);
    chk("t2_instr_c6", id_instr_o, 32'hC0DE_0000);
    imem_req_ready_i = 1'b0;
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    id_ready_i = 1'b1;
    wait_drain("t2_drain");

    // Redirect with two fetches outstanding: both responses dropped.
    do_reset(3);
    f0 = fire_cnt;
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    tick(); tick();
    chk("t3_outstanding", 32'(fire_cnt - f0), 32'd2);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    chk("t3_pc_next", pc_next_o, 32'h100);
    chk("t3_req_redirect", 32'(imem_req_valid_o), 32'd0);
    push_exp(32'h100, 32'hC0DE_0100);
    push_exp(32'h104, 32'hC0DE_0104);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t3_drain_c3", 32'(imem_req_valid_o), 32'd0);
    tick();
    chk("t3_drain_c4", 32'(imem_req_valid_o), 32'd0);
    tick();
    chk("t3_run_c5", 32'(imem_req_valid_o), 32'd1);
    chk("t3_addr_c5", imem_req_addr_o, 32'h100);
    wait_pc(32'h108, "t3_reach_pc");
    imem_req_ready_i = 1'b0;
    wait_drain("t3_drain");

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    tick(); tick();
    chk("t4_valid_before", 32'(id_valid_o), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    push_exp(32'h200, 32'hC0DE_0200);
    push_exp(32'h204, 32'hC0DE_0204);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t4_flushed", 32'(id_valid_o), 32'd0);
    chk("t4_req_run", 32'(imem_req_valid_o), 32'd1);
    chk("t4_addr", imem_req_addr_o, 32'h200);
    wait_pc(32'h208, "t4_reach_pc");
    imem_req_ready_i = 1'b0;
    wait_drain("t4_drain");

    // PC wrap at the top of the address space.
    do_reset(1);
    f0 = fire_cnt;
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("t5_addr", imem_req_addr_o, 32'hFFFF_FFFC);
    chk("t5_pc_wrap", pc_next_o, 32'h0);
    push_exp(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    tick();
    imem_req_ready_i = 1'b0;
    wait_drain("t5_drain");
    chk("t5_fires", 32'(fire_cnt - f0), 32'd1);

    // Asynchronous reset with fetches in flight.
    do_reset(3);
    rst = 1'b1; imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("t6_id_valid", 32'(id_valid_o), 32'd0);
    chk("t6_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("t6_pc_next", pc_next_o, 32'h0);
    tick(); tick();
    imem_req_ready_i = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t6_quiet_after", 32'(id_valid_o), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
